// File: rtl/sm_mem_pkg.sv
// Shared types and helpers for the SM lane memory sequencer.
package sm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Bit offset of lane 'lane' inside a flat bus of 'width'-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/lane_pick.sv
// Lowest-set-bit finder: index of the lowest pending lane plus an empty flag.
module lane_pick #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] idx,
    output logic             none
);

    // Scan from the top so the lowest set bit is the final assignment.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx  = IDX_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sm_lane_mem_sequencer.sv
// Serialises per-lane SP loads/stores onto one memory port in ascending lane
// order, reusing the previous read's data when consecutive read addresses match.
module sm_lane_mem_sequencer
    import sm_mem_pkg::*;
#(
    parameter int N_CORES  = 8,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int COALESCE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      MRead,
    input  logic                      MWrite,
    input  logic [N_CORES-1:0]        en,
    input  logic [N_CORES*ADDR_W-1:0] lane_addr,
    input  logic [N_CORES*DATA_W-1:0] lane_wdata,
    output logic [N_CORES*DATA_W-1:0] lane_q,
    output logic                      MReady,
    output logic                      busy,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ack,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef logic [N_CORES-1:0][ADDR_W-1:0] addr_arr_t;
    typedef logic [N_CORES-1:0][DATA_W-1:0] data_arr_t;

    addr_arr_t addr_in;
    data_arr_t wdata_in;

    state_e             state_q, state_d;
    logic               op_q, op_d;
    logic [N_CORES-1:0] pend_q, pend_d;
    addr_arr_t          addr_q, addr_d;
    data_arr_t          wdata_q, wdata_d;
    data_arr_t          lane_q_q, lane_q_d;
    logic [IDX_W-1:0]   lane_idx_q, lane_idx_d;
    logic               last_vld_q, last_vld_d;
    logic [ADDR_W-1:0]  last_addr_q, last_addr_d;
    logic [DATA_W-1:0]  last_data_q, last_data_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_none;
    logic               coalesce_hit;

    for (genvar g = 0; g < N_CORES; g++) begin : g_lane
        assign addr_in[g]  = lane_addr[lane_lsb(g, ADDR_W) +: ADDR_W];
        assign wdata_in[g] = lane_wdata[lane_lsb(g, DATA_W) +: DATA_W];
        assign lane_q[lane_lsb(g, DATA_W) +: DATA_W] = lane_q_q[g];
    end

    lane_pick #(
        .N     (N_CORES),
        .IDX_W (IDX_W)
    ) u_pick (
        .mask (pend_q),
        .idx  (pick_idx),
        .none (pick_none)
    );

    // Only the immediately preceding serviced read in this operation can be reused.
    assign coalesce_hit = (COALESCE != 0) && (op_q == OP_READ) && last_vld_q &&
                          (addr_q[pick_idx] == last_addr_q);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        pend_d      = pend_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lane_q_d    = lane_q_q;
        lane_idx_d  = lane_idx_q;
        last_vld_d  = last_vld_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (MRead || MWrite) begin
                    op_d       = MRead ? OP_READ : OP_WRITE;
                    pend_d     = en;
                    addr_d     = addr_in;
                    wdata_d    = wdata_in;
                    last_vld_d = 1'b0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (pick_none) begin
                    state_d = DONE;
                end else if (coalesce_hit) begin
                    lane_q_d[pick_idx] = last_data_q;
                    pend_d[pick_idx]   = 1'b0;
                end else begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = op_q;
                    mem_addr_d  = addr_q[pick_idx];
                    mem_wdata_d = wdata_q[pick_idx];
                    lane_idx_d  = pick_idx;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack && mem_req_q) begin
                    if (op_q == OP_READ) begin
                        lane_q_d[lane_idx_q] = mem_rdata;
                        last_data_d          = mem_rdata;
                        last_addr_d          = mem_addr_q;
                        last_vld_d           = 1'b1;
                    end
                    pend_d[lane_idx_q] = 1'b0;
                    mem_req_d          = 1'b0;
                    state_d            = SCAN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= OP_READ;
            pend_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lane_q_q    <= '0;
            lane_idx_q  <= '0;
            last_vld_q  <= 1'b0;
            last_addr_q <= '0;
            last_data_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            pend_q      <= pend_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lane_q_q    <= lane_q_d;
            lane_idx_q  <= lane_idx_d;
            last_vld_q  <= last_vld_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign MReady    = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sm_lane_mem_sequencer.sv
// Scoreboard bench: expected memory accesses and MReady cycles are queued by
// the stimulus and consumed by an independent negedge monitor.
module tb_sm_lane_mem_sequencer;

    localparam int N = 8;
    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            MRead, MWrite;
    logic [N-1:0]    en;
    logic [N*AW-1:0] lane_addr;
    logic [N*DW-1:0] lane_wdata;
    logic [N*DW-1:0] lane_q;
    logic            MReady, busy;
    logic            mem_req, mem_we, mem_ack;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;

    logic            nc_MRead;
    logic [N*DW-1:0] nc_lane_q;
    logic            nc_MReady, nc_busy, nc_mem_req, nc_mem_we;
    logic [AW-1:0]   nc_mem_addr;
    logic [DW-1:0]   nc_mem_wdata;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   nc_acc = 0;
    int   ack_delay = 0;
    int   wait_cnt = 0;
    logic rd_fixed = 1'b0;

    acc_t exp_mem[$];
    int   exp_done[$];

    sm_lane_mem_sequencer #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .COALESCE(1)) u_dut (
        .clk(clk), .reset(reset), .MRead(MRead), .MWrite(MWrite), .en(en),
        .lane_addr(lane_addr), .lane_wdata(lane_wdata), .lane_q(lane_q),
        .MReady(MReady), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    sm_lane_mem_sequencer #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .COALESCE(0)) u_dut_nc (
        .clk(clk), .reset(reset), .MRead(nc_MRead), .MWrite(1'b0), .en(en),
        .lane_addr(lane_addr), .lane_wdata(lane_wdata), .lane_q(nc_lane_q),
        .MReady(nc_MReady), .busy(nc_busy), .mem_req(nc_mem_req), .mem_we(nc_mem_we),
        .mem_addr(nc_mem_addr), .mem_wdata(nc_mem_wdata), .mem_ack(nc_mem_req),
        .mem_rdata(16'hBEEF)
    );

    always #5 clk = ~clk;

    // Memory model: ack after ack_delay wait cycles, read data = addr + 0x100 or fixed.
    assign mem_ack   = mem_req && (wait_cnt == ack_delay);
    assign mem_rdata = rd_fixed ? 16'hBEEF : mem_addr + 16'h0100;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_acc(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        acc_t e;
        e.we = we; e.addr = a; e.wdata = d;
        exp_mem.push_back(e);
    endtask

    // Monitor: pops expected accesses/completions as the DUT presents them.
    initial begin : monitor
        acc_t e;
        logic          p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
        logic [AW-1:0] p_addr = '0;
        logic [DW-1:0] p_wdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && p_req && !p_ack) begin
                chk("hold_addr", 128'(mem_addr), 128'(p_addr));
                chk("hold_we", 128'(mem_we), 128'(p_we));
                chk("hold_wdata", 128'(mem_wdata), 128'(p_wdata));
            end
            if (mem_req && mem_ack) begin
                if (exp_mem.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_access: got addr %h we %b expected none", mem_addr, mem_we);
                end else begin
                    e = exp_mem.pop_front();
                    chk("acc_we", 128'(mem_we), 128'(e.we));
                    chk("acc_addr", 128'(mem_addr), 128'(e.addr));
                    if (e.we) chk("acc_wdata", 128'(mem_wdata), 128'(e.wdata));
                end
            end
            if (MReady) begin
                if (exp_done.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_mready: got pulse at cycle %0d expected none", cyc);
                end else begin
                    chk("mready_cycle", 128'(cyc), 128'(exp_done.pop_front()));
                    chk("busy_at_mready", 128'(busy), 128'(1));
                end
                done_cnt++;
            end
            if (nc_mem_req) nc_acc++;
            p_req = mem_req; p_ack = mem_ack; p_we = mem_we;
            p_addr = mem_addr; p_wdata = mem_wdata;
        end
    end

    // Presents one op for a single cycle; exp_lat < 0 means no MReady is expected.
    task automatic start_op(input logic rd, input logic wr, input logic [N-1:0] e,
                            input logic [N*AW-1:0] a, input logic [N*DW-1:0] w,
                            input int exp_lat, output int acc_cyc, output int base);
        @(negedge clk);
        MRead = rd; MWrite = wr; en = e; lane_addr = a; lane_wdata = w;
        acc_cyc = cyc;
        base = done_cnt;
        if (exp_lat >= 0) exp_done.push_back(cyc + exp_lat);
        @(negedge clk);
        MRead = 1'b0; MWrite = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int k;
        for (k = 0; k < 300 && done_cnt == base; k++) @(negedge clk);
        if (done_cnt == base) begin
            n_chk++; n_err++;
            $display("FAIL mready_timeout: got no MReady expected one within 300 cycles");
        end
        @(negedge clk);
        chk("mready_single", 128'(MReady), 128'(0));
        chk("busy_after", 128'(busy), 128'(0));
        chk("exp_mem_drained", 128'(exp_mem.size()), 128'(0));
    endtask

    initial begin
        int a, b, k, nc_done;
        reset = 1'b0; MRead = 1'b0; MWrite = 1'b0; nc_MRead = 1'b0;
        en = '0; lane_addr = '0; lane_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 128'(mem_req), 128'(0));
        chk("rst_mem_we", 128'(mem_we), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_mem_wdata", 128'(mem_wdata), 128'(0));
        chk("rst_mready", 128'(MReady), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_lane_q", lane_q, 128'(0));
        reset = 1'b1;
        @(negedge clk);

        // 8 reads, zero-wait memory: 2 + 2*8 cycles to MReady
        for (int i = 0; i < N; i++) push_acc(1'b0, 16'(i), 16'h0);
        start_op(1'b1, 1'b0, 8'hFF, 128'h0007_0006_0005_0004_0003_0002_0001_0000, '0, 18, a, b);
        wait_done(b);
        chk("rd8_lane_q", lane_q, 128'h0107_0106_0105_0104_0103_0102_0101_0100);

        // Writes on lanes 0,5,7; lane_q untouched
        push_acc(1'b1, 16'h0010, 16'h00A0);
        push_acc(1'b1, 16'h0015, 16'h00A5);
        push_acc(1'b1, 16'h0017, 16'h00A7);
        start_op(1'b0, 1'b1, 8'b1010_0001, 128'h0017_0016_0015_0014_0013_0012_0011_0010,
                 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0, 8, a, b);
        wait_done(b);
        chk("wr_lane_q", lane_q, 128'h0107_0106_0105_0104_0103_0102_0101_0100);

        // Same address on all lanes: 1 access + 7 coalesced scans
        rd_fixed = 1'b1;
        push_acc(1'b0, 16'h0040, 16'h0);
        start_op(1'b1, 1'b0, 8'hFF, {8{16'h0040}}, '0, 11, a, b);
        wait_done(b);
        chk("coal_lane_q", lane_q, {8{16'hBEEF}});

        // Non-coalescing instance: 8 accesses, 18 cycles
        @(negedge clk);
        nc_acc = 0;
        nc_MRead = 1'b1;
        a = cyc;
        @(negedge clk);
        nc_MRead = 1'b0;
        nc_done = -1;
        for (k = 0; k < 100 && nc_done < 0; k++) begin
            if (nc_MReady) nc_done = cyc;
            else @(negedge clk);
        end
        chk("nc_mready_cycle", 128'(nc_done), 128'(a + 18));
        chk("nc_access_count", 128'(nc_acc), 128'(8));
        chk("nc_lane_q", nc_lane_q, {8{16'hBEEF}});
        rd_fixed = 1'b0;

        // Empty enable mask: no access, MReady 2 cycles after accept
        start_op(1'b1, 1'b0, 8'h00, 128'h1234, '0, 2, a, b);
        wait_done(b);
        chk("empty_lane_q", lane_q, {8{16'hBEEF}});

        // MRead and MWrite together: reads only
        push_acc(1'b0, 16'h0020, 16'h0);
        push_acc(1'b0, 16'h0021, 16'h0);
        start_op(1'b1, 1'b1, 8'h03, 128'h0021_0020, 128'h0055_0055, 6, a, b);
        wait_done(b);
        chk("both_lane_q", lane_q, 128'hBEEF_BEEF_BEEF_BEEF_BEEF_BEEF_0121_0120);

        // 5 wait cycles per access; spurious MRead while busy must be ignored
        ack_delay = 5;
        push_acc(1'b0, 16'h0030, 16'h0);
        push_acc(1'b0, 16'h0031, 16'h0);
        start_op(1'b1, 1'b0, 8'h06, 128'h0031_0030_0000, '0, 16, a, b);
        repeat (3) @(negedge clk);
        MRead = 1'b1; en = 8'hFF;
        @(negedge clk);
        MRead = 1'b0;
        wait_done(b);
        chk("slow_lane_q", lane_q, 128'hBEEF_BEEF_BEEF_BEEF_BEEF_0131_0130_0120);
        repeat (4) @(negedge clk);
        chk("no_extra_mready", 128'(done_cnt), 128'(b + 1));
        ack_delay = 0;

        // Reset during lane 3 access
        for (int i = 0; i < 4; i++) push_acc(1'b0, 16'(i), 16'h0);
        start_op(1'b1, 1'b0, 8'hFF, 128'h0007_0006_0005_0004_0003_0002_0001_0000, '0, -1, a, b);
        for (k = 0; k < 50 && cyc != a + 8; k++) @(negedge clk);
        chk("midrst_in_access", 128'(mem_req), 128'(1));
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_mem_req", 128'(mem_req), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_lane_q", lane_q, 128'(0));
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_no_mready", 128'(done_cnt), 128'(b));
        chk("midrst_exp_mem", 128'(exp_mem.size()), 128'(0));

        // Normal read after the abandoned sequence
        push_acc(1'b0, 16'h0005, 16'h0);
        push_acc(1'b0, 16'h0006, 16'h0);
        start_op(1'b1, 1'b0, 8'h81, 128'h0006_0000_0000_0000_0000_0000_0000_0005, '0, 6, a, b);
        wait_done(b);
        chk("post_rst_lane_q", lane_q, 128'h0106_0000_0000_0000_0000_0000_0000_0105);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
